// File: rtl/imem_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imem_loader_if
// Brief    : Instruction-stream input and instruction-memory port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_mode;
  logic [DATA_W-1:0] mem_data_out;

  // Loader side: sinks the stream, drives the memory port.
  modport master (
    input  in_valid, in_data, mem_data_out,
    output in_ready, mem_address, mem_data_in, mem_mode
  );

  // Host / memory side.
  modport slave (
    output in_valid, in_data, mem_data_out,
    input  in_ready, mem_address, mem_data_in, mem_mode
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imem_loader
// Brief    : Streams 32-bit words into the instruction memory at consecutive
//            addresses; optional read-back verify under LOADER_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ACCEPT     = 3'd1,
    S_WRITE      = 3'd2,
    S_NEXT       = 3'd3,
    S_VERIFY_RD  = 3'd4,
    S_VERIFY_CMP = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_data;
  logic              r_zero_done;
  logic [CNT_W-1:0]  w_rem_dec;

  assign w_rem_dec = r_remaining - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_zero_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
            r_zero_done <= (word_count == '0);
          end
        end
        S_ACCEPT: begin
          if (bus.in_valid) r_data <= bus.in_data;
        end
        S_NEXT: begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= w_rem_dec;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next    = r_state;
    bus.in_ready    = 1'b0;
    bus.mem_mode    = 1'b1;
    bus.mem_address = r_addr;
    bus.mem_data_in = r_data;
    busy            = (r_state != S_IDLE);
    cpu_hold        = (r_state != S_IDLE);
    done            = r_zero_done;
    case (r_state)
      S_IDLE: begin
        if (start && (word_count != '0)) w_state_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_mode = 1'b0;
`ifdef LOADER_VERIFY_EN
        w_state_next = S_VERIFY_RD;
`else
        w_state_next = S_NEXT;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY_RD:  w_state_next = S_VERIFY_CMP;
      S_VERIFY_CMP: w_state_next = S_NEXT;
`endif
      S_NEXT: begin
        // Last word: done fires here, so busy drops on the following cycle.
        if (w_rem_dec == '0) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_ACCEPT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef LOADER_VERIFY_EN
  logic r_error;

  // Sticky until the next accepted start; the load carries on regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_error <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_error <= 1'b0;
    end else if ((r_state == S_VERIFY_CMP) && (bus.mem_data_out != r_data)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^bus.mem_data_out;
  assign error       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader (32-bit and 4-bit
//            address instances sharing one stream driver).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam logic [31:0] c_sentinel = 32'hDEAD_BEEF;
  localparam logic [31:0] c_prog [4] = '{32'h2008_0005, 32'h2009_0003,
                                         32'h0109_5020, 32'hAC0A_0000};
`ifdef LOADER_VERIFY_EN
  localparam int c_cpw = 5;
`else
  localparam int c_cpw = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        sel;
  logic        stuck0;
  logic        clr_req;
  logic        busy, cpu_hold, done, error;
  logic        busy2, cpu_hold2, done2, error2;

  int n_pass = 0, n_total = 0, to_fail = 0, stall_bad = 0;
  int cyc = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0, wr2_cnt = 0;
  logic [31:0] mem  [0:15];
  logic [31:0] mem2 [0:15];
  logic [3:0]  wr2_addr [0:15];

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  imem_loader_if #(.ADDR_W(4),  .DATA_W(32)) bus2 ();

  assign bus.in_valid  = in_valid & ~sel;
  assign bus.in_data   = in_data;
  assign bus2.in_valid = in_valid & sel;
  assign bus2.in_data  = in_data;

  imem_loader #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .base_addr(base_addr),
    .word_count(word_count), .bus(bus), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  imem_loader #(.ADDR_W(4), .DATA_W(32), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .base_addr(base_addr[3:0]),
    .word_count(word_count), .bus(bus2), .busy(busy2), .cpu_hold(cpu_hold2),
    .done(done2), .error(error2)
  );

  // Memory models: synchronous read, write on the edge where mem_mode = 0.
  always @(posedge clk) begin
    bus.mem_data_out  <= mem[bus.mem_address[3:0]];
    bus2.mem_data_out <= mem2[bus2.mem_address];
    if (clr_req) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  = c_sentinel;
        mem2[i] = c_sentinel;
      end
    end
    if (bus.mem_mode == 1'b0) begin
      mem[bus.mem_address[3:0]] = stuck0 ? (bus.mem_data_in & ~32'h1) : bus.mem_data_in;
      wr_cnt++;
    end
    if (bus2.mem_mode == 1'b0) begin
      mem2[bus2.mem_address] = bus2.mem_data_in;
      wr2_addr[wr2_cnt[3:0]] = bus2.mem_address;
      wr2_cnt++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    cyc++;
  end

  task automatic clear_mem();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, output int t0);
    t0         = cyc;
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap > 0: hold in_valid low for gap cycles once in_ready is up.
  task automatic send_word(input logic [31:0] d, input int gap);
    int k;
    in_data  = d;
    in_valid = (gap == 0);
    k = 0;
    while (!(sel ? bus2.in_ready : bus.in_ready) && (k < 50)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) to_fail++;
    for (int g = 0; g < gap; g++) begin
      if (!((bus.in_ready === 1'b1) && (bus.mem_mode === 1'b1))) stall_bad++;
      @(negedge clk);
    end
    in_valid = 1'b1;
    @(negedge clk);
    if (gap != 0) in_valid = 1'b0;
  endtask

  task automatic wait_done(output int t1);
    int k;
    k = 0;
    while (!(sel ? done2 : done) && (k < 60)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) to_fail++;
    t1 = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    stuck0 = 1'b0; clr_req = 1'b0; base_addr = '0; word_count = '0;
    repeat (2) @(negedge clk);
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.mem_address !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_address); else n_pass++;
    n_total++; if (bus.mem_data_in !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.mem_data_in); else n_pass++;
    n_total++; if (bus.mem_mode !== 1'b1) $display("FAIL reset_mode: got %b want 1", bus.mem_mode); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL reset_hold: got %b want 0", cpu_hold); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t0, t1, w0, d0;
    clear_mem();
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start(32'd0, 16'd4, t0);
    for (int i = 0; i < 4; i++) begin
      send_word(c_prog[i], 0);
      if (i == 0) begin
        // Busy: this start must be ignored.
        start = 1'b1; base_addr = 32'd8; word_count = 16'd2;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_done(t1);
    n_total++; if ((t1 - t0) !== 4 * c_cpw) $display("FAIL basic_cycles: got %0d want %0d", t1 - t0, 4 * c_cpw); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_after_done: got %b want 0", busy); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL basic_hold_after_done: got %b want 0", cpu_hold); else n_pass++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (mem[i] !== c_prog[i]) $display("FAIL basic_mem%0d: got %h want %h", i, mem[i], c_prog[i]); else n_pass++;
    end
    n_total++; if (mem[8] !== c_sentinel) $display("FAIL basic_ignored_start: mem8 got %h want %h", mem[8], c_sentinel); else n_pass++;
    n_total++; if ((done_cnt - d0) !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
    n_total++; if ((wr_cnt - w0) !== 4) $display("FAIL basic_writes: got %0d want 4", wr_cnt - w0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int t0, t1, w0;
    clear_mem();
    w0 = wr_cnt; stall_bad = 0;
    pulse_start(32'd0, 16'd4, t0);
    for (int i = 0; i < 4; i++) send_word(c_prog[i], 5);
    wait_done(t1);
    repeat (3) @(negedge clk);
    n_total++; if (stall_bad !== 0) $display("FAIL bp_stall: got %0d bad stall cycles want 0", stall_bad); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (mem[i] !== c_prog[i]) $display("FAIL bp_mem%0d: got %h want %h", i, mem[i], c_prog[i]); else n_pass++;
    end
    n_total++; if ((wr_cnt - w0) !== 4) $display("FAIL bp_writes: got %0d want 4", wr_cnt - w0); else n_pass++;
  endtask

  task automatic test_zero_count();
    int t0, w0, b0, d0;
    w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
    pulse_start(32'd3, 16'd0, t0);
    n_total++; if (done !== 1'b1) $display("FAIL zero_done_pulse: got %b want 1", done); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if ((wr_cnt - w0) !== 0) $display("FAIL zero_writes: got %0d want 0", wr_cnt - w0); else n_pass++;
    n_total++; if ((busy_cnt - b0) !== 0) $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt - b0); else n_pass++;
    n_total++; if ((done_cnt - d0) !== 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    int t0, t1, w2;
    logic [3:0] exp_a [3];
    exp_a = '{4'd14, 4'd15, 4'd0};
    clear_mem();
    sel = 1'b1;
    w2 = wr2_cnt;
    pulse_start(32'd14, 16'd3, t0);
    for (int i = 0; i < 3; i++) send_word(c_prog[i], 0);
    wait_done(t1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    sel = 1'b0;
    n_total++; if ((wr2_cnt - w2) !== 3) $display("FAIL wrap_writes: got %0d want 3", wr2_cnt - w2); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (wr2_addr[(w2 + i) % 16] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %0d want %0d", i, wr2_addr[(w2 + i) % 16], exp_a[i]); else n_pass++;
      n_total++; if (mem2[exp_a[i]] !== c_prog[i]) $display("FAIL wrap_mem%0d: got %h want %h", i, mem2[exp_a[i]], c_prog[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_load();
    int t0, d0;
    clear_mem();
    d0 = done_cnt;
    pulse_start(32'd0, 16'd4, t0);
    send_word(c_prog[0], 0);
    send_word(c_prog[1], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL midrst_hold: got %b want 0", cpu_hold); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.mem_mode !== 1'b1) $display("FAIL midrst_mode: got %b want 1", bus.mem_mode); else n_pass++;
    n_total++; if (bus.mem_address !== 32'h0) $display("FAIL midrst_addr: got %h want 0", bus.mem_address); else n_pass++;
    n_total++; if (bus.mem_data_in !== 32'h0) $display("FAIL midrst_wdata: got %h want 0", bus.mem_data_in); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (mem[0] !== c_prog[0]) $display("FAIL midrst_mem0: got %h want %h", mem[0], c_prog[0]); else n_pass++;
    n_total++; if (mem[1] !== c_prog[1]) $display("FAIL midrst_mem1: got %h want %h", mem[1], c_prog[1]); else n_pass++;
    n_total++; if (mem[2] !== c_sentinel) $display("FAIL midrst_mem2: got %h want %h", mem[2], c_sentinel); else n_pass++;
    n_total++; if (mem[3] !== c_sentinel) $display("FAIL midrst_mem3: got %h want %h", mem[3], c_sentinel); else n_pass++;
    n_total++; if ((done_cnt - d0) !== 0) $display("FAIL midrst_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_verify();
    int t0, t1;
`ifdef LOADER_VERIFY_EN
    clear_mem();
    stuck0 = 1'b1;
    pulse_start(32'd4, 16'd1, t0);
    send_word(32'h0000_0001, 0);
    wait_done(t1);
    n_total++; if (error !== 1'b1) $display("FAIL verify_error_set: got %b want 1", error); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    stuck0 = 1'b0;
    pulse_start(32'd5, 16'd1, t0);
    n_total++; if (error !== 1'b0) $display("FAIL verify_error_clear: got %b want 0", error); else n_pass++;
    send_word(32'h0000_0001, 0);
    wait_done(t1);
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (error !== 1'b0) $display("FAIL verify_good_load: got %b want 0", error); else n_pass++;
    n_total++; if (mem[4] !== 32'h0) $display("FAIL verify_stuck_mem: got %h want 0", mem[4]); else n_pass++;
    n_total++; if (mem[5] !== 32'h1) $display("FAIL verify_good_mem: got %h want 1", mem[5]); else n_pass++;
`else
    clear_mem();
    stuck0 = 1'b1;
    pulse_start(32'd4, 16'd1, t0);
    send_word(32'h0000_0001, 0);
    wait_done(t1);
    @(negedge clk);
    in_valid = 1'b0;
    stuck0 = 1'b0;
    n_total++; if (error !== 1'b0) $display("FAIL noverify_error: got %b want 0", error); else n_pass++;
    n_total++; if (mem[4] !== 32'h0) $display("FAIL noverify_mem: got %h want 0", mem[4]); else n_pass++;
`endif
  endtask

  task automatic test_timeouts();
    n_total++; if (to_fail !== 0) $display("FAIL wait_bounds: got %0d expired waits want 0", to_fail); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_addr_wrap();
    test_reset_mid_load();
    test_verify();
    test_timeouts();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
